vga_fb_fetch: RTL

//  Framebuffer fetch sequencer for the AXI4 VGA datapath: on each frame start, issues AXI4 INCR read

---
 rtl/vga_fb_fetch_pkg.sv | 23 ++
 rtl/vga_fb_fetch_if.sv | 28 ++
 rtl/vga_fb_fetch_len.sv | 45 ++++
 rtl/vga_fb_fetch.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/vga_fb_fetch_pkg.sv
// Shared types and constants for the framebuffer fetch sequencer.
package vga_fb_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ADDR = 2'd2,
    ST_DATA = 2'd3
  } fetch_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int FRAME_W = 24;  // frame length in beats
  localparam int BLEN_W  = 9;   // requested/computed beats per burst
  localparam int ARLEN_W = 8;

  // AXI size encoding for a beat of the given byte count
  function automatic logic [2:0] axi_size(input int bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/vga_fb_fetch_if.sv
// AXI4 read address / read data channels between the fetch sequencer and the memory port.
interface vga_fb_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [3:0]            arid;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid, rready,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid, rready,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/vga_fb_fetch_len.sv
// Beats-per-burst calculation: clamp the request, limit to what is left of the frame and,
// with VGA_FB_FETCH_4K_SPLIT_EN defined, stop each burst at the next 4 KiB boundary.
module vga_fb_fetch_len
  import vga_fb_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic [BLEN_W-1:0]     burst_len_i,
  input  logic [FRAME_W-1:0]    rem_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [BLEN_W-1:0]     beats_o
);

  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  logic [BLEN_W-1:0] clamp;
  logic              unused_addr;

`ifdef VGA_FB_FETCH_4K_SPLIT_EN
  logic [12:0] bytes_left;
  logic [12:0] beats_4k;
  assign unused_addr = ^addr_i[ADDR_WIDTH-1:12];
`else
  assign unused_addr = ^addr_i;
`endif

  // clamp, then min against remaining frame beats (and the 4K page limit when enabled)
  always_comb begin
    clamp = burst_len_i;
    if (clamp == '0) clamp = BLEN_W'(1);
    else if (clamp > BLEN_W'(MAX_BURST)) clamp = BLEN_W'(MAX_BURST);

    beats_o = clamp;
    if (rem_i < FRAME_W'(clamp)) beats_o = rem_i[BLEN_W-1:0];

`ifdef VGA_FB_FETCH_4K_SPLIT_EN
    bytes_left = 13'd4096 - {1'b0, addr_i[11:0]};
    beats_4k   = bytes_left >> BEAT_SHIFT;
    if ({4'b0, beats_o} > beats_4k) beats_o = beats_4k[BLEN_W-1:0];
`endif
  end

endmodule

// File: rtl/vga_fb_fetch.sv
// Framebuffer fetch sequencer: per frame, issues AXI4 INCR bursts from base_addr_i and
// streams returned beats into the pixel line FIFO, one burst outstanding at a time.
// Optional build macro: VGA_FB_FETCH_4K_SPLIT_EN (no burst crosses a 4 KiB page).
//
// state   | meaning
// IDLE    | no frame in progress
// WAIT    | burst size known, waiting for FIFO room
// ADDR    | AR presented, held until arready
// DATA    | accepting R beats until rlast
module vga_fb_fetch
  import vga_fb_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_AW    = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [FRAME_W-1:0]    frame_words_i,
  input  logic [BLEN_W-1:0]     burst_len_i,
  input  logic                  frame_start_i,
  input  logic [FIFO_AW:0]      fifo_free_i,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  vga_fb_fetch_if.master        axi,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic                  err_clr_i
);

  localparam int         BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] AR_SIZE    = axi_size(DATA_WIDTH / 8);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [FRAME_W-1:0]    rem_q, rem_d;
  logic [BLEN_W-1:0]     beats_q, beats_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ARLEN_W-1:0]    arlen_q, arlen_d;
  logic                  discard_q, discard_d;
  logic                  err_q, err_d;
  logic [BLEN_W-1:0]     beats_calc;
  logic                  last_beat;
  logic                  frame_ok;

  vga_fb_fetch_len #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) u_len (
    .burst_len_i (burst_len_i),
    .rem_i       (rem_q),
    .addr_i      (addr_q),
    .beats_o     (beats_calc)
  );

  assign axi.arvalid = (state_q == ST_ADDR);
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = axi.arvalid ? AR_SIZE : 3'd0;
  assign axi.arburst = axi.arvalid ? AXI_BURST_INCR : 2'b00;
  assign axi.arid    = 4'd0;
  assign axi.rready  = (state_q == ST_DATA);
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;

  assign last_beat = (state_q == ST_DATA) && axi.rvalid && axi.rlast;
  assign frame_ok  = en_i && (frame_words_i != '0);

  // next-state, burst bookkeeping and FIFO push
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beats_d   = beats_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    discard_d = discard_q;
    err_d     = err_q;
    wr_en_o   = 1'b0;
    wr_data_o = '0;
    done_o    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_start_i && frame_ok) begin
          addr_d  = base_addr_i;
          rem_d   = frame_words_i;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!en_i) begin
          state_d = ST_IDLE;
        end else if (frame_start_i) begin
          // nothing in flight: restart the frame immediately
          addr_d  = base_addr_i;
          rem_d   = frame_words_i;
          state_d = frame_ok ? ST_WAIT : ST_IDLE;
        end else if (32'(fifo_free_i) >= 32'(beats_calc)) begin
          araddr_d = addr_q;
          arlen_d  = ARLEN_W'(beats_calc - BLEN_W'(1));
          beats_d  = beats_calc;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (frame_start_i) discard_d = 1'b1;
        if (axi.arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        wr_data_o = axi.rdata;
        wr_en_o   = axi.rvalid && !discard_q;
        if (frame_start_i) discard_d = 1'b1;
        if (last_beat) begin
          if (!discard_q) begin
            addr_d = addr_q + (ADDR_WIDTH'(beats_q) << BEAT_SHIFT);
            rem_d  = rem_q - FRAME_W'(beats_q);
            done_o = (rem_q == FRAME_W'(beats_q));
          end
          if (discard_q || frame_start_i) begin
            addr_d    = base_addr_i;
            rem_d     = frame_words_i;
            discard_d = 1'b0;
            state_d   = frame_ok ? ST_WAIT : ST_IDLE;
          end else if (done_o || !en_i) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // clear wins over a same-cycle error beat
    if (err_clr_i) err_d = 1'b0;
    else if ((state_q == ST_DATA) && axi.rvalid && (axi.rresp != AXI_RESP_OKAY)) err_d = 1'b1;
  end

  // state and datapath registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beats_q   <= beats_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      discard_q <= discard_d;
      err_q     <= err_d;
    end
  end

endmodule
